// File: rtl/etc_tile_stream_adapter_if.sv
// etc_tile_stream_adapter_if: valid/ready element stream carrying a tile op and a last marker
interface etc_tile_stream_adapter_if #(
    parameter int W = 16
);
    logic valid;
    logic ready;
    logic last;
    logic [W-1:0] data;
    logic [1:0] op;
    modport master(output valid, data, op, last, input ready);
    modport slave(input valid, data, op, last, output ready);
endinterface

// File: rtl/etc_tile_stream_adapter.sv
// etc_tile_stream_adapter: packs serial A/B operands into 4x4 tiles for the ETC core
// and streams the captured result back out, half-duplex.
module etc_tile_stream_adapter #(
    parameter int W = 16,
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    etc_tile_stream_adapter_if.slave s,
    etc_tile_stream_adapter_if.master m,
    output logic [1:0] etc_op,
    output logic [16*W-1:0] etc_inA,
    output logic [16*W-1:0] etc_inB,
    input  logic [16*W-1:0] etc_out,
    output logic busy,
    output logic [15:0] tiles_done
);
    localparam int CW = $clog2(LAT + 2);
    typedef enum logic [1:0] {LOAD, WAIT, DRAIN} state_t;
    state_t state;
    logic [4:0] idx;
    logic [3:0] ridx;
    logic [CW-1:0] wcnt;
    logic [16*W-1:0] res;
    logic valid_q;
    logic last_q;
    assign s.ready = state == LOAD;
    assign m.valid = valid_q;
    assign m.last = last_q;
    assign m.data = res[ridx*W +: W];
    assign m.op = etc_op;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= LOAD;
            idx <= '0;
            ridx <= '0;
            wcnt <= '0;
            res <= '0;
            etc_op <= '0;
            etc_inA <= '0;
            etc_inB <= '0;
            valid_q <= 1'b0;
            last_q <= 1'b0;
            busy <= 1'b0;
            tiles_done <= '0;
        end else begin
            case (state)
                LOAD: if (s.valid) begin
                    if (idx == 5'd0) etc_op <= s.op;
                    if (!idx[4]) etc_inA[idx[3:0]*W +: W] <= s.data;
                    else etc_inB[idx[3:0]*W +: W] <= s.data;
                    idx <= idx + 5'd1;
                    if (idx == 5'd31) begin
                        state <= WAIT;
                        wcnt <= CW'(LAT);
                        busy <= 1'b1;
                    end
                end
                WAIT: if (wcnt == '0) begin
                    res <= etc_out;
                    ridx <= '0;
                    valid_q <= 1'b1;
                    last_q <= 1'b0;
                    state <= DRAIN;
                end else wcnt <= wcnt - 1'b1;
                DRAIN: if (m.ready) begin
                    if (ridx == 4'd15) begin
                        ridx <= '0;
                        valid_q <= 1'b0;
                        last_q <= 1'b0;
                        busy <= 1'b0;
                        tiles_done <= tiles_done + 16'd1;
                        state <= LOAD;
                    end else begin
                        ridx <= ridx + 4'd1;
                        last_q <= ridx == 4'd14;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_etc_tile_stream_adapter.sv
// tb_etc_tile_stream_adapter: directed tile streams through the adapter with a
// two-register behavioural core stub; expected results are hand-derived per scenario.
module tb_etc_tile_stream_adapter;
    localparam int W = 16;
    localparam int LAT = 2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [1:0] etc_op;
    logic [16*W-1:0] etc_inA, etc_inB, etc_out, ia, ib;
    logic [1:0] iop;
    logic busy;
    logic [15:0] tiles_done;
    logic [W-1:0] ta[16], tbv[16], exp_r[16];
    int vecs = 0;
    int errs = 0;
    int accepts = 0;

    etc_tile_stream_adapter_if #(.W(W)) snk();
    etc_tile_stream_adapter_if #(.W(W)) src();

    etc_tile_stream_adapter #(.W(W), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .s(snk), .m(src),
        .etc_op(etc_op), .etc_inA(etc_inA), .etc_inB(etc_inB), .etc_out(etc_out),
        .busy(busy), .tiles_done(tiles_done)
    );

    always #5 clk = ~clk;

    function automatic logic [16*W-1:0] core(input logic [16*W-1:0] a, input logic [16*W-1:0] b,
                                             input logic [1:0] op);
        logic [16*W-1:0] r;
        logic [W-1:0] acc, x, y;
        r = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                acc = '0;
                if (op == 2'd0) begin
                    for (int k = 0; k < 4; k++) begin
                        x = a[(i*4+k)*W +: W];
                        y = b[(k*4+j)*W +: W];
                        acc = acc + W'(x * y);
                    end
                end else begin
                    x = a[(i*4+j)*W +: W];
                    y = b[(i*4+j)*W +: W];
                    acc = x < y ? x : y;
                end
                r[(i*4+j)*W +: W] = acc;
            end
        return r;
    endfunction

    // Core stub: operand register then result register.
    always @(posedge clk) begin
        ia <= etc_inA;
        ib <= etc_inB;
        iop <= etc_op;
        etc_out <= core(ia, ib, iop);
    end

    always @(posedge clk) if (snk.valid && snk.ready) accepts <= accepts + 1;

    task automatic do_reset();
        rst_n = 1'b0;
        snk.valid = 1'b0;
        src.ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push(input logic [W-1:0] d, input logic [1:0] op);
        int n = 0;
        snk.valid = 1'b1;
        snk.data = d;
        snk.op = op;
        while (!snk.ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            errs++;
            $display("FAIL push_timeout: s_ready stayed %b, want 1", snk.ready);
        end
        @(negedge clk);
    endtask

    // Elements after the first carry a different op that the adapter must ignore.
    task automatic send_tile(input logic [1:0] op0, input bit gap, input int n);
        for (int i = 0; i < n; i++) begin
            push(i < 16 ? ta[i] : tbv[i-16], i == 0 ? op0 : (op0 == 2'd0 ? 2'd3 : 2'd0));
            if (gap) begin
                snk.valid = 1'b0;
                @(negedge clk);
            end
        end
        snk.valid = 1'b0;
    endtask

    task automatic drain(input int stall, input string nm);
        int k = 0;
        int n = 0;
        while (k < 16 && n < 600) begin
            @(negedge clk);
            n++;
            src.ready = 1'b0;
            if (src.valid) begin
                vecs++;
                if (src.data !== exp_r[k] || src.last !== (k == 15) || busy !== 1'b1) begin
                    errs++;
                    $display("FAIL %s r%0d: data=%h last=%b busy=%b, want data=%h last=%b busy=1",
                             nm, k, src.data, src.last, busy, exp_r[k], k == 15);
                end
                src.ready = $urandom_range(0, 99) >= stall;
                if (src.ready) k++;
            end
        end
        vecs++;
        if (k < 16) begin
            errs++;
            $display("FAIL %s_timeout: got %0d results, want 16", nm, k);
        end
        @(negedge clk);
        src.ready = 1'b0;
        vecs++;
        if (src.valid !== 1'b0 || busy !== 1'b0 || snk.ready !== 1'b1) begin
            errs++;
            $display("FAIL %s_end: m_valid=%b busy=%b s_ready=%b, want 0 0 1",
                     nm, src.valid, busy, snk.ready);
        end
    endtask

    task automatic check_tiles(input logic [15:0] want, input string nm);
        vecs++;
        if (tiles_done !== want) begin
            errs++;
            $display("FAIL %s_tiles: tiles_done=%0d, want %0d", nm, tiles_done, want);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vecs++;
        if (snk.ready !== 1'b1 || src.valid !== 1'b0 || src.last !== 1'b0 || src.data !== '0 ||
            busy !== 1'b0 || etc_op !== 2'd0 || etc_inA !== '0 || etc_inB !== '0) begin
            errs++;
            $display("FAIL reset: s_ready=%b m_valid=%b m_last=%b m_data=%h busy=%b op=%0d, want 1 0 0 0 0 0",
                     snk.ready, src.valid, src.last, src.data, busy, etc_op);
        end
        check_tiles(16'd0, "reset");
    endtask

    task automatic test_identity();
        for (int i = 0; i < 16; i++) begin
            ta[i] = (i % 5 == 0) ? 16'd1 : 16'd0;
            tbv[i] = 16'(i + 1);
            exp_r[i] = 16'(i + 1);
        end
        send_tile(2'd0, 1'b0, 32);
        drain(0, "identity");
        check_tiles(16'd1, "identity");
    endtask

    task automatic test_bubbles();
        int a0 = accepts;
        for (int i = 0; i < 16; i++) begin
            ta[i] = 16'd2;
            tbv[i] = 16'd3;
            exp_r[i] = 16'h18;
        end
        send_tile(2'd0, 1'b1, 32);
        vecs++;
        if (accepts - a0 !== 32 || etc_op !== 2'd0) begin
            errs++;
            $display("FAIL bubbles_accepts: accepts=%0d op=%0d, want 32 0", accepts - a0, etc_op);
        end
        drain(0, "bubbles");
        check_tiles(16'd2, "bubbles");
    endtask

    task automatic test_minop();
        for (int i = 0; i < 16; i++) begin
            ta[i] = 16'(2 * i);
            tbv[i] = 16'd10;
            exp_r[i] = (2 * i < 10) ? 16'(2 * i) : 16'd10;
        end
        send_tile(2'd1, 1'b0, 32);
        vecs++;
        if (etc_op !== 2'd1 || busy !== 1'b1 || snk.ready !== 1'b0) begin
            errs++;
            $display("FAIL minop_wait: op=%0d busy=%b s_ready=%b, want 1 1 0", etc_op, busy, snk.ready);
        end
        drain(0, "minop");
        check_tiles(16'd3, "minop");
    endtask

    task automatic test_stall();
        for (int i = 0; i < 16; i++) begin
            ta[i] = (i % 5 == 0) ? 16'd1 : 16'd0;
            tbv[i] = 16'(100 - i);
            exp_r[i] = 16'(100 - i);
        end
        send_tile(2'd0, 1'b0, 32);
        drain(30, "stall");
        check_tiles(16'd4, "stall");
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 16; i++) begin
            ta[i] = 16'(7 + i);
            tbv[i] = 16'(9 + i);
        end
        send_tile(2'd2, 1'b0, 20);
        do_reset();
        vecs++;
        if (snk.ready !== 1'b1 || busy !== 1'b0 || src.valid !== 1'b0 || etc_inA !== '0 || etc_op !== 2'd0) begin
            errs++;
            $display("FAIL midreset: s_ready=%b busy=%b m_valid=%b op=%0d, want 1 0 0 0",
                     snk.ready, busy, src.valid, etc_op);
        end
        check_tiles(16'd0, "midreset");
        for (int i = 0; i < 16; i++) begin
            ta[i] = (i % 5 == 0) ? 16'd1 : 16'd0;
            tbv[i] = 16'(50 + i);
            exp_r[i] = 16'(50 + i);
        end
        send_tile(2'd0, 1'b0, 32);
        drain(0, "midreset");
        repeat (5) @(negedge clk);
        vecs++;
        if (src.valid !== 1'b0) begin
            errs++;
            $display("FAIL midreset_extra: m_valid=%b, want 0", src.valid);
        end
        check_tiles(16'd1, "midreset");
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int t = 0; t < 3; t++) begin
            int cnt = 0;
            int n = 0;
            for (int i = 0; i < 16; i++) begin
                ta[i] = (i % 5 == 0) ? 16'd1 : 16'd0;
                tbv[i] = 16'(16 * t + i + 1);
                exp_r[i] = 16'(16 * t + i + 1);
            end
            send_tile(2'd0, 1'b0, 32);
            while (!src.valid && n < 50) begin
                if (!snk.ready) cnt++;
                @(negedge clk);
                n++;
            end
            vecs++;
            if (cnt != LAT + 1) begin
                errs++;
                $display("FAIL b2b_wait%0d: s_ready low %0d cycles, want %0d", t, cnt, LAT + 1);
            end
            drain(0, "b2b");
        end
        check_tiles(16'd3, "b2b");
    endtask

    initial begin
        snk.valid = 1'b0;
        snk.data = '0;
        snk.op = 2'd0;
        snk.last = 1'b0;
        src.ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_identity();
        test_bubbles();
        test_minop();
        test_stall();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
